// File: rtl/float_to_fixed_norm_mc.sv
// Multi-channel IEEE-754 single to signed fixed-point converter.
// One shared 4-cycle datapath serves CH channels through a round-robin arbiter.
module float_to_fixed_norm_mc #(
  parameter int CH   = 2,
  parameter int OW   = 32,
  parameter int FRAC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CH-1:0]      begin_req,
  input  logic [32*CH-1:0]   f,
  output logic [CH-1:0]      ack,
  output logic [OW*CH-1:0]   result,
  output logic [CH-1:0]      ovf,
  output logic [CH-1:0]      unf,
  output logic               busy
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int MW = OW + 2;
  localparam int WW = 58;
  localparam logic signed [9:0] LMAX    = 10'(WW - 24);
  localparam logic [MW:0]       POS_LIM = {4'b0, {(OW-1){1'b1}}};
  localparam logic [MW:0]       NEG_LIM = POS_LIM + 1'b1;
  localparam logic [OW-1:0]     MAX_OUT = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0]     MIN_OUT = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DECODE, SHIFT, ROUND} state_t;
  typedef enum logic [2:0] {C_ZERO, C_DENORM, C_NORMAL, C_INF, C_NAN} cls_t;

  state_t                 state_reg;
  logic [CH-1:0]          begin_q;
  logic [CH-1:0]          req_reg;
  logic [CH-1:0]          req_next;
  logic [CW-1:0]          ptr_reg;
  logic [CW-1:0]          cur_ch_reg;
  logic [31:0]            f_lat_reg;
  logic                   sign_reg;
  cls_t                   cls_reg;
  logic signed [9:0]      sh_reg;
  logic [23:0]            sig_reg;
  logic [MW-1:0]          mag_reg;
  logic                   rnd_reg;
  logic                   sat_reg;

  logic [31:0]            f_arr [CH];
  logic [CH-1:0]          in_svc;
  logic [CH-1:0]          grant_mask;
  logic                   grant_valid;
  logic                   grant_fire;
  logic [CW-1:0]          grant_ch;
  int                     arb_idx;

  cls_t                   cls_c;
  logic signed [9:0]      sh_c;
  logic [WW-1:0]          wide_c;
  logic [24:0]            rs_c;
  logic [9:0]             rsh_c;
  logic                   rnd_c;
  logic                   lsat_c;
  logic                   sat_c;
  logic [MW:0]            rounded_c;
  logic [MW:0]            neg_c;
  logic [OW-1:0]          res_c;
  logic                   ovf_c;
  logic                   unf_c;

  // Round-robin: scan offsets from the far end so the nearest set request wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    arb_idx     = 0;
    for (int k = CH - 1; k >= 0; k--) begin
      arb_idx = int'(ptr_reg) + k;
      if (arb_idx >= CH) arb_idx = arb_idx - CH;
      if (req_reg[arb_idx]) begin
        grant_valid = 1'b1;
        grant_ch    = CW'(arb_idx);
      end
    end
  end

  assign grant_fire = (state_reg == IDLE) && grant_valid;
  assign req_next   = (req_reg & ~grant_mask) | (begin_req & ~begin_q & ~req_reg & ~in_svc);
  assign busy       = (state_reg != IDLE) || (|req_reg);

  always_comb begin
    cls_c = C_NORMAL;
    if (f_lat_reg[30:23] == 8'h00)
      cls_c = (f_lat_reg[22:0] == 23'd0) ? C_ZERO : C_DENORM;
    else if (f_lat_reg[30:23] == 8'hFF)
      cls_c = (f_lat_reg[22:0] == 23'd0) ? C_INF : C_NAN;
    sh_c = $signed({2'b00, f_lat_reg[30:23]}) - 10'sd150 + 10'(FRAC);
  end

  // Right shifts carry one extra LSB below the significand as the round bit.
  always_comb begin
    wide_c = '0;
    rs_c   = '0;
    rsh_c  = -sh_reg;
    rnd_c  = 1'b0;
    lsat_c = 1'b0;
    if (!sh_reg[9]) begin
      if (sh_reg > LMAX) lsat_c = 1'b1;
      else               wide_c = WW'(sig_reg) << sh_reg;
    end else if (rsh_c < 10'd25) begin
      rs_c   = {sig_reg, 1'b0} >> rsh_c;
      wide_c = WW'(rs_c[24:1]);
      rnd_c  = rs_c[0];
    end
    sat_c = lsat_c | (|wide_c[WW-1:MW]);
  end

  always_comb begin
    rounded_c = {1'b0, mag_reg} + {{MW{1'b0}}, rnd_reg};
    neg_c     = ~rounded_c + 1'b1;
    res_c     = '0;
    ovf_c     = 1'b0;
    unf_c     = 1'b0;
    case (cls_reg)
      C_ZERO:   res_c = '0;
      C_DENORM: unf_c = 1'b1;
      C_INF: begin
        res_c = sign_reg ? MIN_OUT : MAX_OUT;
        ovf_c = 1'b1;
      end
      C_NAN: begin
        res_c = MAX_OUT;
        ovf_c = 1'b1;
      end
      default: begin
        if (sat_reg || rounded_c > (sign_reg ? NEG_LIM : POS_LIM)) begin
          res_c = sign_reg ? MIN_OUT : MAX_OUT;
          ovf_c = 1'b1;
        end else begin
          res_c = sign_reg ? neg_c[OW-1:0] : rounded_c[OW-1:0];
          unf_c = (rounded_c == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      begin_q    <= '0;
      req_reg    <= '0;
      ptr_reg    <= '0;
      cur_ch_reg <= '0;
      f_lat_reg  <= '0;
      sign_reg   <= 1'b0;
      cls_reg    <= C_ZERO;
      sh_reg     <= '0;
      sig_reg    <= '0;
      mag_reg    <= '0;
      rnd_reg    <= 1'b0;
      sat_reg    <= 1'b0;
    end else begin
      begin_q <= begin_req;
      req_reg <= req_next;
      case (state_reg)
        IDLE: begin
          if (grant_fire) begin
            f_lat_reg  <= f_arr[grant_ch];
            cur_ch_reg <= grant_ch;
            ptr_reg    <= (grant_ch == CW'(CH - 1)) ? '0 : grant_ch + 1'b1;
            state_reg  <= DECODE;
          end
        end
        DECODE: begin
          sign_reg  <= f_lat_reg[31];
          cls_reg   <= cls_c;
          sh_reg    <= sh_c;
          sig_reg   <= {1'b1, f_lat_reg[22:0]};
          state_reg <= SHIFT;
        end
        SHIFT: begin
          mag_reg   <= wide_c[MW-1:0];
          rnd_reg   <= rnd_c;
          sat_reg   <= sat_c;
          state_reg <= ROUND;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic          ack_reg;
    logic [OW-1:0] result_reg;
    logic          ovf_reg;
    logic          unf_reg;

    assign f_arr[gi]      = f[32*gi +: 32];
    // A channel being granted or already in flight cannot queue a second request.
    assign in_svc[gi]     = ((state_reg != IDLE) && (cur_ch_reg == CW'(gi))) ||
                            (grant_fire && (grant_ch == CW'(gi)));
    assign grant_mask[gi] = grant_fire && (grant_ch == CW'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ack_reg    <= 1'b0;
        result_reg <= '0;
        ovf_reg    <= 1'b0;
        unf_reg    <= 1'b0;
      end else begin
        ack_reg <= 1'b0;
        if (state_reg == ROUND && cur_ch_reg == CW'(gi)) begin
          ack_reg    <= 1'b1;
          result_reg <= res_c;
          ovf_reg    <= ovf_c;
          unf_reg    <= unf_c;
        end
      end
    end

    assign ack[gi]              = ack_reg;
    assign result[OW*gi +: OW]  = result_reg;
    assign ovf[gi]              = ovf_reg;
    assign unf[gi]              = unf_reg;
  end

endmodule

// File: tb/tb_float_to_fixed_norm_mc.sv
// Scoreboard bench for float_to_fixed_norm_mc: expected results are queued at
// stimulus time and popped when the matching ACK appears.
module tb_float_to_fixed_norm_mc;
  localparam int CH = 2;
  localparam int OW = 32;
  localparam int FRAC = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH-1:0]     begin_req = '0;
  logic [32*CH-1:0]  f = '0;
  logic [CH-1:0]     ack;
  logic [OW*CH-1:0]  result;
  logic [CH-1:0]     ovf;
  logic [CH-1:0]     unf;
  logic              busy;

  float_to_fixed_norm_mc #(.CH(CH), .OW(OW), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .begin_req(begin_req), .f(f),
    .ack(ack), .result(result), .ovf(ovf), .unf(unf), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            ch;
    logic [OW-1:0] res;
    logic          o;
    logic          u;
    int            at;
  } exp_t;

  typedef struct {
    int            ch;
    logic [31:0]   fv;
    logic [OW-1:0] res;
    logic          o;
    logic          u;
  } vec_t;

  exp_t sb[$];
  logic [OW-1:0] last_res [CH];
  logic          last_ovf [CH];
  logic          last_unf [CH];
  int n_vec = 0;
  int n_bad = 0;

  vec_t vecs [15] = '{
    '{0, 32'h3F800000, 32'h00010000, 1'b0, 1'b0},
    '{0, 32'hC0200000, 32'hFFFD8000, 1'b0, 1'b0},
    '{0, 32'h37400000, 32'h00000001, 1'b0, 1'b0},
    '{0, 32'h37000000, 32'h00000001, 1'b0, 1'b0},
    '{0, 32'h36800000, 32'h00000000, 1'b0, 1'b1},
    '{0, 32'h00000001, 32'h00000000, 1'b0, 1'b1},
    '{0, 32'h47800000, 32'h7FFFFFFF, 1'b1, 1'b0},
    '{0, 32'hC7000000, 32'h80000000, 1'b0, 1'b0},
    '{0, 32'hFF800000, 32'h80000000, 1'b1, 1'b0},
    '{0, 32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0},
    '{1, 32'h42F60000, 32'h007B0000, 1'b0, 1'b0},
    '{1, 32'hBF000000, 32'hFFFF8000, 1'b0, 1'b0},
    '{1, 32'h80000000, 32'h00000000, 1'b0, 1'b0},
    '{1, 32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0},
    '{1, 32'h47000000, 32'h7FFFFFFF, 1'b1, 1'b0}
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Drive a rise on one channel now and queue its expected outcome.
  task automatic drive(input int ch, input logic [31:0] fv, input logic [OW-1:0] r,
                       input logic o, input logic u, input int at);
    exp_t e;
    f[32*ch +: 32] = fv;
    begin_req[ch]  = 1'b1;
    e.ch = ch; e.res = r; e.o = o; e.u = u; e.at = at;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic single(input vec_t v);
    @(negedge clk);
    drive(v.ch, v.fv, v.res, v.o, v.u, cyc + 5);
    drain(20);
    @(negedge clk);
    begin_req[v.ch] = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ack != '0) begin
      if (sb.size() == 0) begin
        check("spurious_ack", 64'(ack), 64'd0);
      end else begin
        e = sb.pop_front();
        check("ack_vec", 64'(ack), 64'd1 << e.ch);
        last_res[e.ch] = e.res;
        last_ovf[e.ch] = e.o;
        last_unf[e.ch] = e.u;
        for (int c = 0; c < CH; c++) begin
          check($sformatf("result_ch%0d", c), 64'(result[OW*c +: OW]), 64'(last_res[c]));
          check($sformatf("ovf_ch%0d", c), 64'(ovf[c]), 64'(last_ovf[c]));
          check($sformatf("unf_ch%0d", c), 64'(unf[c]), 64'(last_unf[c]));
        end
        if (e.at >= 0) check("latency", 64'(cyc), 64'(e.at));
        $display("ack ch%0d result=%08h ovf=%0d unf=%0d cycle=%0d",
                 e.ch, result[OW*e.ch +: OW], ovf[e.ch], unf[e.ch], cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    for (int c = 0; c < CH; c++) begin
      last_res[c] = '0; last_ovf[c] = 1'b0; last_unf[c] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_result", 64'(result), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_unf", 64'(unf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) single(vecs[i]);

    // Simultaneous rises: ch0 then ch1 four cycles later, twice.
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      e0 = cyc;
      drive(0, 32'h3F800000, 32'h00010000, 1'b0, 1'b0, e0 + 5);
      drive(1, 32'hC0200000, 32'hFFFD8000, 1'b0, 1'b0, e0 + 9);
      drain(30);
      @(negedge clk);
      begin_req = '0;
      @(negedge clk);
    end

    // ch1 rises alone while ch0 is in service.
    @(negedge clk);
    e0 = cyc;
    drive(0, 32'h40000000, 32'h00020000, 1'b0, 1'b0, e0 + 5);
    repeat (2) @(negedge clk);
    drive(1, 32'h3F000000, 32'h00008000, 1'b0, 1'b0, e0 + 9);
    drain(30);
    @(negedge clk);
    begin_req = '0;
    @(negedge clk);

    // Holding BEGIN high yields one conversion only.
    @(negedge clk);
    drive(0, 32'h40400000, 32'h00030000, 1'b0, 1'b0, cyc + 5);
    repeat (20) @(negedge clk);
    drain(10);
    begin_req = '0;
    repeat (3) @(negedge clk);

    // Second rise on ch0 while its request is still pending is dropped.
    @(negedge clk);
    e0 = cyc;
    drive(1, 32'h40800000, 32'h00040000, 1'b0, 1'b0, e0 + 5);
    @(negedge clk);
    drive(0, 32'h40A00000, 32'h00050000, 1'b0, 1'b0, e0 + 9);
    @(negedge clk);
    begin_req[0] = 1'b0;
    @(negedge clk);
    begin_req[0] = 1'b1;
    drain(30);
    repeat (15) @(negedge clk);
    begin_req = '0;
    repeat (2) @(negedge clk);

    // Reset while the conversion sits in SHIFT.
    @(negedge clk);
    drive(0, 32'hC0200000, 32'hFFFD8000, 1'b0, 1'b0, -1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_ack", 64'(ack), 64'd0);
    check("mid_rst_ovf", 64'(ovf), 64'd0);
    check("mid_rst_unf", 64'(unf), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    sb.delete();
    for (int c = 0; c < CH; c++) begin
      last_res[c] = '0; last_ovf[c] = 1'b0; last_unf[c] = 1'b0;
    end
    begin_req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    single(vecs[1]);
    single(vecs[10]);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
